// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//   Multi-cycle WIDTH-bit adder. Operands are captured on an input handshake,
//   then added one nibble per clock through a single 4-bit carry-lookahead
//   unit. The group carry is kept in a register between nibbles
//   (next = GG | (PG & carry)). The result is held until the consumer takes it.
//
//   Optional build macro: SIGNED_OVF_EN adds a registered signed-overflow output.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operands present
//   in_ready   block can accept operands (IDLE and not in reset)
//   in0, in1   WIDTH-bit operands
//   carry_in   carry into bit 0
//   out_valid  result available
//   out_ready  consumer takes result
//   sum        registered (in0 + in1 + carry_in) mod 2^WIDTH
//   carry_out  carry out of bit WIDTH-1
//   overflow   signed overflow (SIGNED_OVF_EN only)

// 4-bit carry-lookahead unit: nibble sum plus group propagate/generate.
module nibble_cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       pg,
    output logic       gg
);
    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] c;

    assign p = a ^ b;
    assign g = a & b;

    assign c[0] = cin;
    assign c[1] = g[0] | (p[0] & cin);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);

    assign s  = p ^ c;
    assign pg = &p;
    assign gg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]);
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
`ifdef SIGNED_OVF_EN
    ,
    output logic             overflow
`endif
);
    localparam int N    = WIDTH / 4;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   idx_q;
    logic              carry_q;
    logic [WIDTH-1:0]  a_q, b_q, acc_q;
    logic [WIDTH-1:0]  sum_q;
    logic              cout_q;
    logic              out_valid_q;

    logic [3:0]        a_nib, b_nib, s_nib;
    logic              pg, gg;
    logic              carry_next;
    logic [WIDTH-1:0]  acc_next;
    logic              last_step;
    logic              accept;

    // ------------------------------------------------------------------
    // Handshake and control
    // ------------------------------------------------------------------
    assign in_ready  = (state_q == IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign last_step = (idx_q == IDXW'(N - 1));

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)    state_d = RUN;
            RUN:     if (last_step) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Nibble datapath: select the current nibble with constant part-selects
    // so every slice is statically in range for any legal WIDTH.
    // ------------------------------------------------------------------
    always_comb begin
        a_nib = 4'h0;
        b_nib = 4'h0;
        for (int i = 0; i < N; i++) begin
            if (idx_q == IDXW'(i)) begin
                a_nib = a_q[4*i +: 4];
                b_nib = b_q[4*i +: 4];
            end
        end
    end

    nibble_cla4 u_cla (
        .a   (a_nib),
        .b   (b_nib),
        .cin (carry_q),
        .s   (s_nib),
        .pg  (pg),
        .gg  (gg)
    );

    assign carry_next = gg | (pg & carry_q);

    // Accumulator with the current nibble merged in; on the last step this
    // is the complete sum, so it can be loaded straight into the output.
    always_comb begin
        acc_next = acc_q;
        for (int i = 0; i < N; i++) begin
            if (idx_q == IDXW'(i)) acc_next[4*i +: 4] = s_nib;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q       <= '0;
            carry_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            acc_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q     <= in0;
                        b_q     <= in1;
                        carry_q <= carry_in;
                        idx_q   <= '0;
                    end
                end
                RUN: begin
                    acc_q   <= acc_next;
                    carry_q <= carry_next;
                    idx_q   <= idx_q + IDXW'(1);
                    if (last_step) begin
                        sum_q       <= acc_next;
                        cout_q      <= carry_next;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) out_valid_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign carry_out = cout_q;

`ifdef SIGNED_OVF_EN
    // Signed overflow: operands share a sign and the result sign differs.
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (state_q == RUN && last_step) begin
            ovf_q <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                     (acc_next[WIDTH-1] != a_q[WIDTH-1]);
        end
    end

    assign overflow = ovf_q;
`endif

endmodule
